// File: rtl/uart_rx.sv
// UART receiver: 8N1 framing, oversampled by an external tick strobe.
// The line is synchronised, a falling edge in idle starts a frame, and each bit
// is sampled once at a fixed tick index within its bit period.
module uart_rx #(
    parameter int unsigned OVERSAMPLE  = 16,
    parameter int unsigned SAMPLE_TICK = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sck_rising_edge,
    input  logic       sin,
    output logic [7:0] rx_data,
    output logic       rx_data_valid,
    output logic       rx_error,
    output logic       rx_busy
);

    localparam int unsigned TickW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [TickW-1:0] TickLast   = TickW'(OVERSAMPLE - 1);
    localparam logic [TickW-1:0] TickSample = TickW'(SAMPLE_TICK);

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } state_e;

    state_e           state_q, state_d;
    logic [1:0]       sin_sync_q, sin_sync_d;
    logic             sin_d_q, sin_d_d;
    logic [TickW-1:0] tick_q, tick_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       rx_data_q, rx_data_d;
    logic             valid_q, valid_d;
    logic             error_q, error_d;

    logic             sin_s;
    logic             at_sample;
    logic             at_wrap;
    logic [TickW-1:0] tick_next;

    assign sin_s     = sin_sync_q[1];
    assign at_sample = sck_rising_edge && (tick_q == TickSample);
    assign at_wrap   = sck_rising_edge && (tick_q == TickLast);
    assign tick_next = at_wrap ? '0 : tick_q + TickW'(1);

    // Two-flop synchroniser plus one delayed copy for falling-edge detection.
    always_comb begin
        sin_sync_d = {sin_sync_q[0], sin};
        sin_d_d    = sin_s;
    end

    // Frame FSM: next state, counters, shift register and registered pulses.
    always_comb begin
        state_d   = state_q;
        tick_d    = tick_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        rx_data_d = rx_data_q;
        valid_d   = 1'b0;
        error_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (sin_d_q && !sin_s) begin
                    state_d = StStart;
                    tick_d  = '0;
                    bit_d   = '0;
                end
            end
            StStart: begin
                // A line that is high again at the sample point was a glitch.
                if (at_sample && sin_s) begin
                    state_d = StIdle;
                end else if (sck_rising_edge) begin
                    tick_d = tick_next;
                    if (at_wrap) begin
                        state_d = StData;
                    end
                end
            end
            StData: begin
                if (sck_rising_edge) begin
                    tick_d = tick_next;
                    if (at_sample) begin
                        shift_d = {sin_s, shift_q[7:1]};
                    end
                    if (at_wrap) begin
                        if (bit_q == 3'd7) begin
                            state_d = StStop;
                        end else begin
                            bit_d = bit_q + 3'd1;
                        end
                    end
                end
            end
            StStop: begin
                // Leave at the sample point so the next start edge is not missed.
                if (at_sample) begin
                    state_d = StIdle;
                    if (sin_s) begin
                        rx_data_d = shift_q;
                        valid_d   = 1'b1;
                    end else begin
                        error_d = 1'b1;
                    end
                end else if (sck_rising_edge) begin
                    tick_d = tick_next;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State register with synchronous reset; the synchroniser resets to idle-high.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            sin_sync_q <= 2'b11;
            sin_d_q    <= 1'b1;
            tick_q     <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            rx_data_q  <= '0;
            valid_q    <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            sin_sync_q <= sin_sync_d;
            sin_d_q    <= sin_d_d;
            tick_q     <= tick_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            rx_data_q  <= rx_data_d;
            valid_q    <= valid_d;
            error_q    <= error_d;
        end
    end

    assign rx_data       = rx_data_q;
    assign rx_data_valid = valid_q;
    assign rx_error      = error_q;
    assign rx_busy       = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx: directed and random frames against a frame-level model.
module tb_uart_rx;

    localparam int unsigned OS    = 16;
    localparam int unsigned STALL = 200;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sck = 1'b0;
    logic       sin = 1'b1;
    logic [7:0] rx_data;
    logic       rx_data_valid;
    logic       rx_error;
    logic       rx_busy;

    uart_rx #(
        .OVERSAMPLE (OS),
        .SAMPLE_TICK(7)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .sck_rising_edge(sck),
        .sin            (sin),
        .rx_data        (rx_data),
        .rx_data_valid  (rx_data_valid),
        .rx_error       (rx_error),
        .rx_busy        (rx_busy)
    );

    always #5 clk = ~clk;

    int unsigned total  = 0;
    int unsigned passed = 0;

    // Events are {1 = valid / 0 = error, rx_data at that cycle}.
    logic [8:0] obs_q[$];
    logic [8:0] exp_q[$];
    bit         both_seen = 1'b0;
    logic [7:0] last_data = 8'h00;

    // Record every output pulse; a pulse longer than one cycle records twice.
    always @(negedge clk) begin
        if (rx_data_valid) obs_q.push_back({1'b1, rx_data});
        if (rx_error) obs_q.push_back({1'b0, rx_data});
        if (rx_data_valid && rx_error) both_seen = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // One oversample tick = 4 clocks, strobe high for exactly one posedge.
    task automatic tick();
        @(negedge clk) sck = 1'b1;
        @(negedge clk) sck = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic hold(input logic v, input int n);
        sin = v;
        repeat (n) tick();
    endtask

    // Drive one frame; optionally freeze the tick strobe before data bit 'stall'.
    task automatic send_frame(input logic [7:0] b, input logic stop, input int stall);
        hold(1'b0, OS);
        for (int i = 0; i < 8; i++) begin
            if (i == stall) begin
                repeat (STALL) @(negedge clk);
                check("stall busy", rx_busy, 1);
                check("stall no pulse", obs_q.size(), 0);
            end
            hold(b[i], OS);
        end
        hold(stop, OS);
        // Model: a good stop bit delivers the byte, a bad one flags an error and keeps rx_data.
        if (stop) begin
            exp_q.push_back({1'b1, b});
            last_data = b;
        end else begin
            exp_q.push_back({1'b0, last_data});
        end
    endtask

    task automatic check_events(input string tag);
        int n;
        #1;
        check({tag, " count"}, obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check({tag, " event"}, obs_q[i], exp_q[i]);
        end
        check({tag, " exclusive"}, both_seen, 0);
        check({tag, " rx_data"}, rx_data, last_data);
        check({tag, " idle"}, rx_busy, 0);
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " rx_data"}, rx_data, 8'h00);
        check({tag, " valid"}, rx_data_valid, 0);
        check({tag, " error"}, rx_error, 0);
        check({tag, " busy"}, rx_busy, 0);
    endtask

    initial begin
        logic [7:0] rb;
        logic       rs;
        int         gap;

        // Reset state
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        hold(1'b1, 4);

        // Bad stop bit straight after reset: rx_data stays 00
        send_frame(8'h81, 1'b0, -1);
        check_events("frame81 bad stop");
        hold(1'b1, 4);

        // Single good frame
        send_frame(8'h55, 1'b1, -1);
        check_events("frame55");

        // Back-to-back frames, no idle gap
        send_frame(8'hA5, 1'b1, -1);
        send_frame(8'h3C, 1'b1, -1);
        send_frame(8'hFF, 1'b1, -1);
        send_frame(8'h00, 1'b1, -1);
        check_events("back2back");

        // Short low glitch, then a real frame
        hold(1'b0, 4);
        hold(1'b1, 12);
        check_events("glitch");
        send_frame(8'h12, 1'b1, -1);
        check_events("frame12");

        // Tick strobe frozen mid-frame: everything holds
        send_frame(8'h6B, 1'b1, 4);
        check_events("stall frame");

        // Reset during data bit 3 of 0xC3
        hold(1'b0, OS);
        for (int i = 0; i < 3; i++) hold(rb_c3(i), OS);
        sin = rb_c3(3);
        repeat (5) tick();
        check("mid-frame busy", rx_busy, 1);
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        check_reset_outputs("mid-frame reset");
        last_data = 8'h00;
        hold(1'b1, OS);
        check_events("after reset");
        send_frame(8'h7E, 1'b1, -1);
        check_events("frame7E");

        // Break: line low for three frame periods gives exactly one error
        hold(1'b0, 3 * 10 * OS);
        exp_q.push_back({1'b0, last_data});
        hold(1'b1, OS);
        check_events("break");
        send_frame(8'h99, 1'b1, -1);
        check_events("frame99");

        // Random frames, random stop bits, random idle gaps
        for (int k = 0; k < 8; k++) begin
            rb  = 8'($urandom);
            rs  = ($urandom_range(3) != 0);
            send_frame(rb, rs, -1);
            gap = rs ? int'($urandom_range(10)) : int'($urandom_range(10, 2));
            hold(1'b1, gap);
        end
        hold(1'b1, 2);
        check_events("random");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    function automatic logic rb_c3(input int i);
        logic [7:0] v;
        v = 8'hC3;
        return v[i];
    endfunction

    initial begin
        repeat (100000) @(posedge clk);
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
